// File: rtl/multicycle_control.sv
// multicycle_control
//   Control FSM for a multicycle datapath. The FSM walks an instruction through
//   fetch, decode and execute, and drives the datapath strobes and selects.
//   Memory wait states are bounded by a timeout. Unknown opcodes trap, and the
//   FSM then holds in TRAP until reset.
//
// Ports
//   clk, reset      : rising-edge clock; asynchronous active-high reset
//   opcode[5:0]     : instruction[31:26]; sampled only in DECODE
//   mem_ready       : memory handshake; an access completes in any cycle where
//                     mem_ready is high. While it is low the FSM holds the
//                     request steady and counts wait cycles.
//   PCWrite .. PCSource : datapath control strobes and selects
//   state[3:0]      : current state code (debug / checker visibility)
//   retire          : high in the last cycle of an instruction
//   trap, trap_cause: trap flag; cause 01 = illegal opcode, 10 = memory timeout
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_EXEC_I    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_R2    = 6'b010111;
  localparam logic [5:0] OP_ADDI  = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_XORI  = 6'b010010;
  localparam logic [5:0] OP_SLTI  = 6'b011000;
  localparam logic [5:0] OP_BEQ   = 6'b010011;
  localparam logic [5:0] OP_J     = 6'b011001;
  localparam logic [5:0] OP_LW    = 6'b010101;
  localparam logic [5:0] OP_SW    = 6'b010110;

  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] cause_q, cause_d;
  logic       in_wait;
  logic       timeout;

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                   (state_q == S_MEM_WRITE);
  // Trap only once the limit is reached AND memory is still stalling; a
  // completion in the limit cycle takes the normal path.
  assign timeout = in_wait && !mem_ready && (wait_cnt_q >= TIMEOUT_LIM);

  // State register, wait counter, captured opcode and trap cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      wait_cnt_q <= '0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      cause_q    <= cause_d;
      if (state_q == S_DECODE) op_q <= opcode;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        // The live opcode steers this one transition; it is captured into
        // op_q in the same cycle for use by every later state.
        case (opcode)
          OP_RTYPE, OP_R2:                   state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_XORI, OP_SLTI: state_d = S_EXEC_I;
          OP_BEQ:                            state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready) state_d = S_MEM_WB;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEM_WRITE: begin
        if (mem_ready) state_d = S_FETCH;
        else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_EXEC_R: state_d = S_R_WB;
      S_EXEC_I: state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Wait counter: any state change clears it (covers entry into each wait
  // state); it counts only stalled cycles inside a wait state.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q)       wait_cnt_d = '0;
    else if (in_wait && !mem_ready) wait_cnt_d = wait_cnt_q + 8'd1;
  end

  // Output logic.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    PCSource    = 2'b00;
    retire      = 1'b0;
    trap        = 1'b0;
    trap_cause  = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = mem_ready;
        IRWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        retire   = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = mem_ready;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (op_q)
          OP_ADDI: ALUOp = 3'b011;
          OP_ANDI: ALUOp = 3'b100;
          OP_XORI: ALUOp = 3'b101;
          OP_SLTI: ALUOp = 3'b110;
          default: ALUOp = 3'b000;
        endcase
      end
      S_I_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 3'b001;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
      end
      S_TRAP: begin
        trap       = 1'b1;
        trap_cause = cause_q;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Directed bench for multicycle_control. The driver issues one input vector
//   per cycle and pushes the hand-computed output vector for that cycle; the
//   monitor pops and compares on the falling edge.
module tb_multicycle_control;

  localparam int TO = 4;

  // Vector layout: {state, trap_cause, trap, retire,
  //   PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg,
  //   RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource}
  localparam logic [24:0] V_IDLE    = '0;
  localparam logic [24:0] V_FETCH_W = {4'd1,  2'b00, 1'b0, 1'b0, 10'b0000100000, 2'b01, 3'b000, 2'b00};
  localparam logic [24:0] V_FETCH_R = {4'd1,  2'b00, 1'b0, 1'b0, 10'b1001100000, 2'b01, 3'b000, 2'b00};
  localparam logic [24:0] V_DECODE  = {4'd2,  2'b00, 1'b0, 1'b0, 10'b0000000000, 2'b11, 3'b000, 2'b00};
  localparam logic [24:0] V_MADDR   = {4'd3,  2'b00, 1'b0, 1'b0, 10'b0000000001, 2'b10, 3'b000, 2'b00};
  localparam logic [24:0] V_MREAD   = {4'd4,  2'b00, 1'b0, 1'b0, 10'b0010100000, 2'b00, 3'b000, 2'b00};
  localparam logic [24:0] V_MWB     = {4'd5,  2'b00, 1'b0, 1'b1, 10'b0000001010, 2'b00, 3'b000, 2'b00};
  localparam logic [24:0] V_MWR_W   = {4'd6,  2'b00, 1'b0, 1'b0, 10'b0010010000, 2'b00, 3'b000, 2'b00};
  localparam logic [24:0] V_MWR_R   = {4'd6,  2'b00, 1'b0, 1'b1, 10'b0010010000, 2'b00, 3'b000, 2'b00};
  localparam logic [24:0] V_EXR     = {4'd7,  2'b00, 1'b0, 1'b0, 10'b0000000001, 2'b00, 3'b010, 2'b00};
  localparam logic [24:0] V_RWB     = {4'd8,  2'b00, 1'b0, 1'b1, 10'b0000000110, 2'b00, 3'b000, 2'b00};
  localparam logic [24:0] V_IWB     = {4'd10, 2'b00, 1'b0, 1'b1, 10'b0000000010, 2'b00, 3'b000, 2'b00};
  localparam logic [24:0] V_BR      = {4'd11, 2'b00, 1'b0, 1'b1, 10'b0100000001, 2'b00, 3'b001, 2'b01};
  localparam logic [24:0] V_JMP     = {4'd12, 2'b00, 1'b0, 1'b1, 10'b1000000000, 2'b00, 3'b000, 2'b10};
  localparam logic [24:0] V_TRAP_IL = {4'd13, 2'b01, 1'b1, 1'b0, 10'b0000000000, 2'b00, 3'b000, 2'b00};
  localparam logic [24:0] V_TRAP_TO = {4'd13, 2'b10, 1'b1, 1'b0, 10'b0000000000, 2'b00, 3'b000, 2'b00};

  localparam logic [5:0] OP_R  = 6'b000000;
  localparam logic [5:0] OP_R2 = 6'b010111;
  localparam logic [5:0] OP_LW = 6'b010101;
  localparam logic [5:0] OP_SW = 6'b010110;
  localparam logic [5:0] OP_BQ = 6'b010011;
  localparam logic [5:0] OP_J  = 6'b011001;
  localparam logic [5:0] OP_BAD = 6'b111111;

  function automatic logic [24:0] v_exi(input logic [2:0] aluop);
    return {4'd9, 2'b00, 1'b0, 1'b0, 10'b0000000001, 2'b10, aluop, 2'b00};
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode;
  logic mem_ready;
  always #5 clk = ~clk;

  logic PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg;
  logic RegDst, RegWrite, ALUSrcA, retire, trap;
  logic [1:0] ALUSrcB, PCSource, trap_cause;
  logic [2:0] ALUOp;
  logic [3:0] state;

  multicycle_control #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .retire(retire), .trap(trap),
    .trap_cause(trap_cause)
  );

  logic [24:0] dut_vec;
  assign dut_vec = {state, trap_cause, trap, retire, PCWrite, PCWriteCond,
                    IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDst,
                    RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  // ---------------- scoreboard ----------------
  logic [24:0] exp_q[$];
  int          id_q[$];
  int checks = 0;
  int failures = 0;
  int step_no = 0;

  task automatic chk(input string nm, input logic [24:0] act, input logic [24:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [24:0] e;
      int id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      chk($sformatf("cycle_%0d", id), dut_vec, e);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1: apply inputs for this cycle, record what the DUT
  // must show during it, then advance one clock.
  task automatic step(input logic [5:0] op, input logic rdy, input logic [24:0] e);
    opcode    = op;
    mem_ready = rdy;
    exp_q.push_back(e);
    id_q.push_back(step_no);
    step_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_outputs_zero", dut_vec, V_IDLE);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  localparam logic [5:0] I_OPS  [4] = '{6'b010000, 6'b010001, 6'b010010, 6'b011000};
  localparam logic [2:0] I_ALUS [4] = '{3'b011, 3'b100, 3'b101, 3'b110};

  initial begin
    reset     = 1'b1;
    opcode    = OP_R;
    mem_ready = 1'b1;
    #2;
    chk("reset_state", dut_vec, V_IDLE);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(OP_R, 1'b1, V_IDLE);

    // R-type; opcode changed after DECODE to show the captured copy is used.
    step(OP_R,   1'b1, V_FETCH_R);
    step(OP_R,   1'b1, V_DECODE);
    step(OP_BAD, 1'b1, V_EXR);
    step(OP_BAD, 1'b1, V_RWB);

    // lw with three stalled cycles in MEM_READ; live opcode flipped to sw.
    step(OP_LW, 1'b1, V_FETCH_R);
    step(OP_LW, 1'b1, V_DECODE);
    step(OP_SW, 1'b1, V_MADDR);
    for (int i = 0; i < 3; i++) step(OP_SW, 1'b0, V_MREAD);
    step(OP_SW, 1'b1, V_MREAD);
    step(OP_SW, 1'b1, V_MWB);

    // I-type ALU ops.
    for (int i = 0; i < 4; i++) begin
      step(I_OPS[i], 1'b1, V_FETCH_R);
      step(I_OPS[i], 1'b1, V_DECODE);
      step(OP_R,     1'b1, v_exi(I_ALUS[i]));
      step(OP_R,     1'b1, V_IWB);
    end

    // beq, j, sw, second R-type encoding.
    step(OP_BQ, 1'b1, V_FETCH_R);
    step(OP_BQ, 1'b1, V_DECODE);
    step(OP_BQ, 1'b1, V_BR);
    step(OP_J,  1'b1, V_FETCH_R);
    step(OP_J,  1'b1, V_DECODE);
    step(OP_J,  1'b1, V_JMP);
    step(OP_SW, 1'b1, V_FETCH_R);
    step(OP_SW, 1'b1, V_DECODE);
    step(OP_LW, 1'b1, V_MADDR);
    step(OP_LW, 1'b1, V_MWR_R);
    step(OP_R2, 1'b1, V_FETCH_R);
    step(OP_R2, 1'b1, V_DECODE);
    step(OP_R2, 1'b1, V_EXR);
    step(OP_R2, 1'b1, V_RWB);

    // mem_ready rises in the limit cycle: normal path to DECODE.
    for (int i = 0; i < TO; i++) step(OP_J, 1'b0, V_FETCH_W);
    step(OP_J, 1'b1, V_FETCH_R);
    step(OP_J, 1'b1, V_DECODE);
    step(OP_J, 1'b1, V_JMP);

    // mem_ready low for TO+1 cycles in FETCH: timeout trap.
    for (int i = 0; i < TO + 1; i++) step(OP_R, 1'b0, V_FETCH_W);
    for (int i = 0; i < 3; i++) step(OP_R, 1'b1, V_TRAP_TO);
    do_reset();
    step(OP_R, 1'b1, V_IDLE);

    // Illegal opcode: trap held for 20 cycles whatever the inputs do.
    step(OP_BAD, 1'b1, V_FETCH_R);
    step(OP_BAD, 1'b1, V_DECODE);
    for (int i = 0; i < 20; i++)
      step(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), V_TRAP_IL);
    do_reset();
    step(OP_R, 1'b1, V_IDLE);

    // Reset asserted mid-MEM_WRITE, between clock edges.
    step(OP_SW, 1'b1, V_FETCH_R);
    step(OP_SW, 1'b1, V_DECODE);
    step(OP_SW, 1'b1, V_MADDR);
    step(OP_SW, 1'b0, V_MWR_W);
    @(negedge clk);
    #2;
    mem_ready = 1'b1;
    reset     = 1'b1;
    #1;
    chk("async_reset_mid_write", dut_vec, V_IDLE);
    @(posedge clk);
    #1;
    chk("reset_held_over_edge", dut_vec, V_IDLE);
    reset = 1'b0;
    step(OP_R, 1'b1, V_IDLE);
    step(OP_R, 1'b1, V_FETCH_R);
    step(OP_R, 1'b1, V_DECODE);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
